// File: rtl/vga_scan_engine_pkg.sv
// Shared definitions for the VGA scan engine.
//   COLORW           : bits per colour channel
//   VGA640_*         : 640x480@60 timing preset (pixels / lines)
//   vga_ctl_t        : control bundle carried alongside the framebuffer read latency
//   ceil_div()       : elaboration-time ceiling division for framebuffer dimensions
package vga_scan_engine_pkg;

    localparam int unsigned COLORW = 8;

    localparam int unsigned VGA640_H_ACT  = 640;
    localparam int unsigned VGA640_H_FP   = 16;
    localparam int unsigned VGA640_H_SYNC = 96;
    localparam int unsigned VGA640_H_BP   = 48;
    localparam int unsigned VGA640_V_ACT  = 480;
    localparam int unsigned VGA640_V_FP   = 10;
    localparam int unsigned VGA640_V_SYNC = 2;
    localparam int unsigned VGA640_V_BP   = 33;

    typedef struct packed {
        logic       active;
        logic       hs;        // sync asserted (polarity applied at the pins)
        logic       vs;
        logic       win_valid;
        logic [2:0] win_id;
    } vga_ctl_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter with wrap, active and sync flags.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_step         : advance by one (pixel clock for H, line wrap for V)
//   o_cnt          : current position 0..TOTAL-1
//   o_last         : position is TOTAL-1
//   o_active       : position < ACT
//   o_sync         : position within [ACT+FP, ACT+FP+SYNC), polarity-free
module vga_axis_counter #(
    parameter int unsigned W    = 11,
    parameter int unsigned ACT  = 640,
    parameter int unsigned FP   = 16,
    parameter int unsigned SYNC = 96,
    parameter int unsigned BP   = 48
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_step,
    output logic [W-1:0] o_cnt,
    output logic         o_last,
    output logic         o_active,
    output logic         o_sync
);

    localparam int unsigned TOTAL = ACT + FP + SYNC + BP;

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= o_last ? '0 : r_cnt + W'(1);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_last   = (r_cnt == W'(TOTAL - 1));
    assign o_active = (r_cnt < W'(ACT));
    assign o_sync   = (r_cnt >= W'(ACT + FP)) && (r_cnt < W'(ACT + FP + SYNC));

endmodule

// File: rtl/vga_scan_engine.sv
// VGA scan engine: raster timing, downscaled framebuffer addressing, prioritised overlay
// windows and a latency-aligned RGB/sync output stage.
//   iVGA_CLK, iRST_n : pixel clock, async active-low reset
//   iWIN_EN/iWIN_CFG : per-window enable and {x0,y0,x1,y1}, sampled once per frame
//   iRGB_BG/iRGB_WIN : background / window pixel data, RD_LAT cycles after the address
//   oFB_ADDR, oWIN_* , oFRAME : address stage (one cycle after the counters)
//   oRGB, oHS, oVS, oBLANK_n  : pins, RD_LAT+2 cycles after the counters
module vga_scan_engine
    import vga_scan_engine_pkg::*;
#(
    parameter int unsigned H_ACT  = VGA640_H_ACT,
    parameter int unsigned H_FP   = VGA640_H_FP,
    parameter int unsigned H_SYNC = VGA640_H_SYNC,
    parameter int unsigned H_BP   = VGA640_H_BP,
    parameter int unsigned V_ACT  = VGA640_V_ACT,
    parameter int unsigned V_FP   = VGA640_V_FP,
    parameter int unsigned V_SYNC = VGA640_V_SYNC,
    parameter int unsigned V_BP   = VGA640_V_BP,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0,
    parameter int unsigned SCALE  = 5,
    parameter int unsigned AW     = 20,
    parameter int unsigned CW     = 11,
    parameter int unsigned NWIN   = 2,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     iVGA_CLK,
    input  logic                     iRST_n,
    input  logic [NWIN-1:0]          iWIN_EN,
    input  logic [NWIN*4*CW-1:0]     iWIN_CFG,
    input  logic [3*COLORW-1:0]      iRGB_BG,
    input  logic [NWIN*3*COLORW-1:0] iRGB_WIN,
    output logic [AW-1:0]            oFB_ADDR,
    output logic                     oWIN_VALID,
    output logic [2:0]               oWIN_ID,
    output logic [CW-1:0]            oWIN_X,
    output logic [CW-1:0]            oWIN_Y,
    output logic                     oFRAME,
    output logic [3*COLORW-1:0]      oRGB,
    output logic                     oHS,
    output logic                     oVS,
    output logic                     oBLANK_n
);

    localparam int unsigned FB_W    = ceil_div(H_ACT, SCALE);
    localparam int unsigned SXW     = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SXW-1:0] SX_LAST = SXW'(SCALE - 1);
    localparam int unsigned RGBW    = 3 * COLORW;

    // ---------------- raster counters ----------------
    logic [CW-1:0] w_hcnt, w_vcnt;
    logic w_h_last, w_v_last, w_h_act, w_v_act, w_h_sync, w_v_sync;
    logic w_active, w_frame_end;

    vga_axis_counter #(.W(CW), .ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_hcnt (
        .i_clk    (iVGA_CLK),
        .i_rst_n  (iRST_n),
        .i_step   (1'b1),
        .o_cnt    (w_hcnt),
        .o_last   (w_h_last),
        .o_active (w_h_act),
        .o_sync   (w_h_sync)
    );

    vga_axis_counter #(.W(CW), .ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_vcnt (
        .i_clk    (iVGA_CLK),
        .i_rst_n  (iRST_n),
        .i_step   (w_h_last),
        .o_cnt    (w_vcnt),
        .o_last   (w_v_last),
        .o_active (w_v_act),
        .o_sync   (w_v_sync)
    );

    assign w_active    = w_h_act && w_v_act;
    assign w_frame_end = w_h_last && w_v_last;

    // ---------------- replication counters (no divide/multiply) ----------------
    logic [SXW-1:0] r_sx, r_sy;
    logic [AW-1:0]  r_fbx, r_row_base;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_sx       <= '0;
            r_fbx      <= '0;
            r_sy       <= '0;
            r_row_base <= '0;
        end else begin
            if (w_h_last) begin
                r_sx  <= '0;
                r_fbx <= '0;
            end else if (w_active) begin
                if (r_sx == SX_LAST) begin
                    r_sx  <= '0;
                    r_fbx <= r_fbx + AW'(1);
                end else begin
                    r_sx <= r_sx + SXW'(1);
                end
            end
            if (w_frame_end) begin
                r_sy       <= '0;
                r_row_base <= '0;
            end else if (w_h_last && w_v_act) begin
                // Overshoot after the last active row is harmless: cleared before reuse.
                if (r_sy == SX_LAST) begin
                    r_sy       <= '0;
                    r_row_base <= r_row_base + AW'(FB_W);
                end else begin
                    r_sy <= r_sy + SXW'(1);
                end
            end
        end
    end

    // ---------------- window shadows and hit test ----------------
    logic [NWIN-1:0]      r_win_en;
    logic [NWIN*4*CW-1:0] r_win_cfg;

    // Latched only at the very last pixel of the frame so a frame never tears.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_win_en  <= '0;
            r_win_cfg <= '0;
        end else if (w_frame_end) begin
            r_win_en  <= iWIN_EN;
            r_win_cfg <= iWIN_CFG;
        end
    end

    logic [CW-1:0]   w_x0 [NWIN];
    logic [CW-1:0]   w_y0 [NWIN];
    logic [CW-1:0]   w_x1 [NWIN];
    logic [CW-1:0]   w_y1 [NWIN];
    logic [NWIN-1:0] w_in_win;

    for (genvar g = 0; g < NWIN; g++) begin : g_win
        assign w_x0[g]     = r_win_cfg[g*4*CW + 3*CW +: CW];
        assign w_y0[g]     = r_win_cfg[g*4*CW + 2*CW +: CW];
        assign w_x1[g]     = r_win_cfg[g*4*CW + 1*CW +: CW];
        assign w_y1[g]     = r_win_cfg[g*4*CW +: CW];
        // Half-open ranges make x0>=x1 or y0>=y1 naturally empty.
        assign w_in_win[g] = r_win_en[g] && (w_hcnt >= w_x0[g]) && (w_hcnt < w_x1[g]) &&
                             (w_vcnt >= w_y0[g]) && (w_vcnt < w_y1[g]);
    end

    logic          w_hit;
    logic [2:0]    w_hit_id;
    logic [CW-1:0] w_hit_x, w_hit_y;

    // Scan from highest index down so the lowest matching index is left standing.
    always_comb begin
        w_hit    = 1'b0;
        w_hit_id = '0;
        w_hit_x  = '0;
        w_hit_y  = '0;
        for (int i = int'(NWIN) - 1; i >= 0; i--) begin
            if (w_in_win[i]) begin
                w_hit    = 1'b1;
                w_hit_id = 3'(i);
                w_hit_x  = w_hcnt - w_x0[i];
                w_hit_y  = w_vcnt - w_y0[i];
            end
        end
    end

    // ---------------- stage A ----------------
    logic r_act_a, r_hs_a, r_vs_a;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oFB_ADDR   <= '0;
            oFRAME     <= 1'b0;
            oWIN_VALID <= 1'b0;
            oWIN_ID    <= '0;
            oWIN_X     <= '0;
            oWIN_Y     <= '0;
            r_act_a    <= 1'b0;
            r_hs_a     <= 1'b0;
            r_vs_a     <= 1'b0;
        end else begin
            if (w_active) begin
                oFB_ADDR <= r_row_base + r_fbx;
            end
            oFRAME     <= (w_hcnt == '0) && (w_vcnt == '0);
            oWIN_VALID <= w_hit;
            oWIN_ID    <= w_hit_id;
            oWIN_X     <= w_hit_x;
            oWIN_Y     <= w_hit_y;
            r_act_a    <= w_active;
            r_hs_a     <= w_h_sync;
            r_vs_a     <= w_v_sync;
        end
    end

    // ---------------- stage B: match framebuffer read latency ----------------
    vga_ctl_t w_ctl_a, w_ctl_b;

    assign w_ctl_a = '{active: r_act_a, hs: r_hs_a, vs: r_vs_a,
                       win_valid: oWIN_VALID, win_id: oWIN_ID};

    if (RD_LAT == 0) begin : g_no_dly
        assign w_ctl_b = w_ctl_a;
    end else begin : g_dly
        vga_ctl_t r_dly [RD_LAT];
        always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
            if (!iRST_n) begin
                for (int i = 0; i < int'(RD_LAT); i++) r_dly[i] <= '0;
            end else begin
                r_dly[0] <= w_ctl_a;
                for (int i = 1; i < int'(RD_LAT); i++) r_dly[i] <= r_dly[i-1];
            end
        end
        assign w_ctl_b = r_dly[RD_LAT-1];
    end

    // ---------------- stage C: pixel mux and pins ----------------
    logic [RGBW-1:0] w_win_rgb;

    always_comb begin
        w_win_rgb = '0;
        for (int i = 0; i < int'(NWIN); i++) begin
            if (w_ctl_b.win_id == 3'(i)) w_win_rgb = iRGB_WIN[i*RGBW +: RGBW];
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oRGB     <= '0;
            oHS      <= ~HS_POL;
            oVS      <= ~VS_POL;
            oBLANK_n <= 1'b0;
        end else begin
            oRGB     <= !w_ctl_b.active    ? '0        :
                        w_ctl_b.win_valid ? w_win_rgb : iRGB_BG;
            oHS      <= w_ctl_b.hs ? HS_POL : ~HS_POL;
            oVS      <= w_ctl_b.vs ? VS_POL : ~VS_POL;
            oBLANK_n <= w_ctl_b.active;
        end
    end

endmodule
